// File: rtl/alu_op_sequencer_if.sv
// Board-side bundle between switches/buttons/ALU and the operand sequencer.
interface alu_op_sequencer_if #(
   parameter int unsigned NB_DATA      = 8,
   parameter int unsigned NB_OPCODE    = 6,
   parameter int unsigned N_PULSADORES = 3
);
   logic [NB_DATA-1:0]      i_switches;
   logic [N_PULSADORES-1:0] i_pulsadores;
   logic [NB_DATA-1:0]      i_alu_result;
   logic [NB_DATA-1:0]      o_data_a;
   logic [NB_DATA-1:0]      o_data_b;
   logic [NB_OPCODE-1:0]    o_opcode;
   logic [NB_DATA-1:0]      o_result;
   logic                    o_valid;
   logic                    o_op_err;
   logic                    o_seq_err;
   logic [2:0]              o_state;

   // Board / ALU side: drives switches, buttons and the ALU result.
   modport master (
      output i_switches, i_pulsadores, i_alu_result,
      input  o_data_a, o_data_b, o_opcode, o_result, o_valid, o_op_err, o_seq_err, o_state
   );

   // Sequencer side.
   modport slave (
      input  i_switches, i_pulsadores, i_alu_result,
      output o_data_a, o_data_b, o_opcode, o_result, o_valid, o_op_err, o_seq_err, o_state
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Button-driven operand/opcode sequencer for the board ALU: debounces the buttons,
// enforces the A -> B -> opcode load order and registers the ALU result.
module alu_op_sequencer #(
   parameter int unsigned NB_DATA         = 8,
   parameter int unsigned NB_OPCODE       = 6,
   parameter int unsigned N_PULSADORES    = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic              i_clock,
   input logic              i_reset,
   alu_op_sequencer_if.slave bus
);

   localparam int unsigned NB_CNT = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
   localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
   localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
   localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
   localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
   localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
   localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
   localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Button conditioning state
   logic [N_PULSADORES-1:0] sync1_q, sync1_d;
   logic [N_PULSADORES-1:0] sync2_q, sync2_d;
   logic [N_PULSADORES-1:0] db_q, db_d;
   logic [N_PULSADORES-1:0] ev_q, ev_d;
   logic [NB_CNT-1:0]       cnt_q [N_PULSADORES];
   logic [NB_CNT-1:0]       cnt_d [N_PULSADORES];

   // Sequencer state
   state_t               state_q, state_d;
   logic [NB_DATA-1:0]   data_a_q, data_a_d;
   logic [NB_DATA-1:0]   data_b_q, data_b_d;
   logic [NB_OPCODE-1:0] opcode_q, opcode_d;
   logic [NB_DATA-1:0]   result_q, result_d;
   logic                 valid_q, valid_d;
   logic                 op_err_q, op_err_d;
   logic                 seq_err_q, seq_err_d;

   logic                 sel_a, sel_b, sel_op, code_ok;
   logic [NB_OPCODE-1:0] code;

   function automatic logic op_valid(input logic [NB_OPCODE-1:0] c);
      case (c)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_valid = 1'b1;
         default:                                                        op_valid = 1'b0;
      endcase
   endfunction

   // Synchronizer, mismatch counter and rising-edge press event per button
   always_comb begin
      sync1_d = bus.i_pulsadores;
      sync2_d = sync1_q;
      db_d    = db_q;
      ev_d    = '0;
      for (int i = 0; i < int'(N_PULSADORES); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
               db_d[i] = sync2_q[i];
               ev_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + NB_CNT'(1);
            end
         end
      end
   end

   // Button conditioning registers
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         ev_q    <= '0;
         for (int i = 0; i < int'(N_PULSADORES); i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         ev_q    <= ev_d;
         for (int i = 0; i < int'(N_PULSADORES); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Next state and load decisions; only the highest-priority event is honoured
   always_comb begin
      state_d   = state_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      opcode_d  = opcode_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      op_err_d  = op_err_q;
      seq_err_d = seq_err_q;
      sel_a     = ev_q[0];
      sel_b     = ev_q[1] & ~ev_q[0];
      sel_op    = ev_q[2] & ~ev_q[1] & ~ev_q[0];
      code      = bus.i_switches[NB_OPCODE-1:0];
      code_ok   = op_valid(code);
      case (state_q)
         S_A: begin
            if (sel_a) begin
               data_a_d  = bus.i_switches;
               seq_err_d = 1'b0;
               op_err_d  = 1'b0;
               state_d   = S_B;
            end else if (sel_b || sel_op) begin
               seq_err_d = 1'b1;
            end
         end
         S_B: begin
            if (sel_a) begin
               data_a_d = bus.i_switches;
            end else if (sel_b) begin
               data_b_d = bus.i_switches;
               state_d  = S_OP;
            end else if (sel_op) begin
               seq_err_d = 1'b1;
            end
         end
         S_OP: begin
            if (sel_a) begin
               data_a_d = bus.i_switches;
               state_d  = S_B;
            end else if (sel_b) begin
               data_b_d = bus.i_switches;
            end else if (sel_op) begin
               if (code_ok) begin
                  opcode_d = code;
                  op_err_d = 1'b0;
                  state_d  = S_EXEC;
               end else begin
                  op_err_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            result_d = bus.i_alu_result;
            valid_d  = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (sel_a) begin
               data_a_d = bus.i_switches;
               state_d  = S_B;
            end else if (sel_b) begin
               seq_err_d = 1'b1;
            end else if (sel_op) begin
               if (code_ok) begin
                  opcode_d = code;
                  op_err_d = 1'b0;
                  state_d  = S_EXEC;
               end else begin
                  op_err_d = 1'b1;
               end
            end
         end
         default: state_d = S_A;
      endcase
   end

   // Sequencer registers
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= S_A;
         data_a_q  <= '0;
         data_b_q  <= '0;
         opcode_q  <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         op_err_q  <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         opcode_q  <= opcode_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         op_err_q  <= op_err_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign bus.o_data_a  = data_a_q;
   assign bus.o_data_b  = data_b_q;
   assign bus.o_opcode  = opcode_q;
   assign bus.o_result  = result_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_op_err  = op_err_q;
   assign bus.o_seq_err = seq_err_q;
   assign bus.o_state   = state_q;

endmodule
